// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and the signed-operand magnitude helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } mdu_state_e;

    // Widest operand the magnitude helper supports.
    localparam int unsigned MDU_MAXW = 64;
    localparam int unsigned MDU_IW   = $clog2(MDU_MAXW);

    typedef struct packed {
        logic                neg;
        logic [MDU_MAXW-1:0] mag;
    } mdu_abs_t;

    // Treat the low w bits of v as two's complement; return sign and magnitude.
    function automatic mdu_abs_t mdu_abs(input logic [MDU_MAXW-1:0] v, input int unsigned w);
        mdu_abs_t            r;
        logic [MDU_MAXW-1:0] mask;
        mask  = (w >= MDU_MAXW) ? '1 : ((MDU_MAXW'(1) << w) - MDU_MAXW'(1));
        r.neg = v[MDU_IW'(w - 1)];
        r.mag = (r.neg ? -v : v) & mask;
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module mdu_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_sum     = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_operand} : '0);
        w_shifted = {i_upper, i_lower[WIDTH-1]};
        w_fits    = (w_shifted >= {1'b0, i_operand});
        // Partial remainder stays below the divisor, so a WIDTH-bit difference suffices.
        w_diff    = w_shifted[WIDTH-1:0] - i_operand;
        if (i_is_div) begin
            o_upper = w_fits ? w_diff : w_shifted[WIDTH-1:0];
            o_lower = {i_lower[WIDTH-2:0], w_fits};
        end else begin
            o_upper = w_sum[WIDTH:1];
            o_lower = {w_sum[0], i_lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers, MADD/MSUB accumulation
// and flush abort. Operates on magnitudes; signs are restored in FIN. WIDTH <= 64.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    mdu_state_e       r_state;
    mdu_op_e          r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dz;
    logic             r_sa;
    logic             r_sx;
    logic             r_busy;
    logic             r_done;

    mdu_op_e            w_op;
    mdu_abs_t           w_abs_rs;
    mdu_abs_t           w_abs_rt;
    logic               w_signed_op;
    logic               w_is_div;
    logic               w_run_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_upper;
    logic [WIDTH-1:0]   w_step_lower;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;
    logic               w_unused;

    assign w_op     = mdu_op_e'(op);
    assign w_abs_rs = mdu_abs(MDU_MAXW'(rs), WIDTH);
    assign w_abs_rt = mdu_abs(MDU_MAXW'(rt), WIDTH);
    assign w_unused = ^{w_abs_rs.mag, w_abs_rt.mag};

    always_comb begin
        w_signed_op = (w_op == MDU_MULT) || (w_op == MDU_DIV) ||
                      (w_op == MDU_MADD) || (w_op == MDU_MSUB);
        w_is_div    = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
        w_a_mag     = w_signed_op ? w_abs_rs.mag[WIDTH-1:0] : rs;
        w_b_mag     = w_signed_op ? w_abs_rt.mag[WIDTH-1:0] : rt;
        w_run_div   = (r_op == MDU_DIV) || (r_op == MDU_DIVU);
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div  (w_run_div),
        .i_upper   (r_upper),
        .i_lower   (r_lower),
        .i_operand (r_operand),
        .o_upper   (w_step_upper),
        .o_lower   (w_step_lower)
    );

    // Sign fix-up and accumulation applied to the finished magnitude result.
    always_comb begin
        w_prod   = {r_upper, r_lower};
        w_prod_s = r_sx ? -w_prod : w_prod;
        w_hilo   = {r_hi, r_lo};
        case (r_op)
            MDU_MADD: w_acc = w_hilo + w_prod_s;
            MDU_MSUB: w_acc = w_hilo - w_prod_s;
            default:  w_acc = w_prod_s;
        endcase
        w_quo = r_sx ? -r_lower : r_lower;
        w_rem = r_sa ? -r_upper : r_upper;
        if (w_run_div) begin
            w_fin_lo = r_dz ? '1   : w_quo;
            w_fin_hi = r_dz ? r_rs : w_rem;
        end else begin
            {w_fin_hi, w_fin_lo} = w_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= MDU_MULT;
            r_cnt     <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_operand <= '0;
            r_rs      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dz      <= 1'b0;
            r_sa      <= 1'b0;
            r_sx      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (w_op)
                            MDU_MTHI: r_hi <= rs;
                            MDU_MTLO: r_lo <= rs;
                            default: begin
                                r_op    <= w_op;
                                r_state <= S_RUN;
                                r_cnt   <= CNT_INIT;
                                r_busy  <= 1'b1;
                                r_upper <= '0;
                                r_rs    <= rs;
                                r_dz    <= (rt == '0);
                                r_sa    <= w_signed_op & w_abs_rs.neg;
                                r_sx    <= w_signed_op & (w_abs_rs.neg ^ w_abs_rt.neg);
                                // Divide shifts the dividend out of lower; multiply shifts the multiplier.
                                if (w_is_div) begin
                                    r_lower   <= w_a_mag;
                                    r_operand <= w_b_mag;
                                end else begin
                                    r_lower   <= w_b_mag;
                                    r_operand <= w_a_mag;
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_upper <= w_step_upper;
                        r_lower <= w_step_lower;
                        if (r_cnt == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!cancel) begin
                        r_hi   <= w_fin_hi;
                        r_lo   <= w_fin_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes model results, monitor checks on done.
`timescale 1ns/1ps
module tb_mdu_iter;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                           OP_MTHI = 3'd4, OP_MTLO = 3'd5, OP_MADD = 3'd6, OP_MSUB = 3'd7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         cancel;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           e0;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    exp_t         sb[$];
    int           done_cyc[$];
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural reference: HI/LO as plain 64-bit arithmetic on signed/unsigned integers.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            OP_MULT:  begin p = sa * sbv; {mhi, mlo} = p; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {mhi, mlo} = p; end
            OP_DIV: begin
                if (b == '0) begin mlo = '1; mhi = a; end
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
            end
            OP_DIVU: begin
                if (b == '0) begin mlo = '1; mhi = a; end
                else begin mlo = a / b; mhi = a % b; end
            end
            OP_MTHI: mhi = a;
            OP_MTLO: mlo = a;
            OP_MADD: begin p = sa * sbv; {mhi, mlo} = {mhi, mlo} + p; end
            default: begin p = sa * sbv; {mhi, mlo} = {mhi, mlo} - p; end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("done_latency", 64'(cyc - e.e0), 64'(W + 1));
            end
        end
        if (!reset && start && busy) begin
            total++;
            bad++;
            $display("FAIL start_while_busy: got start=1 busy=1 expected start=0 (cycle %0d)", cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

    // All driver tasks are entered just after a falling edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit completes);
        exp_t e;
        op = o; rs = a; rt = b; start = 1'b1;
        if (completes) begin
            model(o, a, b);
            if (o != OP_MTHI && o != OP_MTLO) begin
                e.hi = mhi; e.lo = mlo; e.e0 = cyc + 1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(W + 1));
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(o, a, b, 1'b1);
        if (o == OP_MTHI || o == OP_MTLO) begin
            check("mt_hi", hi, mhi);
            check("mt_lo", lo, mlo);
            check("mt_busy", busy, 0);
        end else begin
            wait_idle();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; rs = '0; rt = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run_op(OP_DIVU, 32'd100, 32'd7);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIV, 32'd5, 32'd0);
        run_op(OP_DIVU, 32'd9, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_MTHI, 32'h1234, 32'd0);
        run_op(OP_MTLO, 32'd0, 32'd0);
        run_op(OP_MADD, 32'd2, 32'd3);
        run_op(OP_MSUB, 32'd2, 32'd4);

        // Abort in RUN cycle 10.
        issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_run_busy", busy, 0);
        check("cancel_run_hi", hi, mhi);
        check("cancel_run_lo", lo, mlo);
        repeat (W + 4) @(negedge clk);

        // Abort in the FIN cycle.
        issue(OP_MULT, 32'h0000_7777, 32'hFFFF_0003, 1'b0);
        repeat (W) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_fin_busy", busy, 0);
        check("cancel_fin_hi", hi, mhi);
        check("cancel_fin_lo", lo, mlo);
        repeat (4) @(negedge clk);

        // Start with cancel in the same cycle is dropped.
        op = OP_MTLO; rs = 32'd7; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_lo", lo, mlo);
        check("start_cancel_busy", busy, 0);
        op = OP_DIVU; rs = 32'd50; rt = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_div_busy", busy, 0);
        repeat (W + 4) @(negedge clk);

        // Reset in RUN cycle 5.
        issue(OP_MULT, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        @(negedge clk);

        // Back-to-back issue in the done cycle.
        run_op(OP_MULT, 32'h0001_0001, 32'hFFFF_FFFF);
        run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(negedge clk);
        if (done_cyc.size() >= 2)
            check("b2b_done_gap", 64'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 64'(W + 2));
        else
            check("b2b_done_count", 64'(done_cyc.size()), 64'd2);

        // Randomised mix of every op class.
        repeat (60) run_op(3'($urandom_range(0, 7)), pick(), pick());

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO architectural registers, sitting beside the EX-stage ALU of the pipelined MIPS core. It accepts one operation per issue, runs a radix-2 shift-add/restoring-divide datapath over WIDTH iterations, and holds the result in HI/LO. Relative to the previous fixed-32-bit unit, it adds:
- a width parameter;
- real bit-serial iteration rather than a modelled delay;
- MADD/MSUB accumulation;
- defined divide-by-zero results;
- mid-operation abort for exception flush.

## Interface
- WIDTH, 32: operand/HI/LO width; even, ≥4.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  issue request; sampled only when busy=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (signed), 7 MSUB (signed).
- rs  in  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt  in  WIDTH  operand B / divisor.
- cancel  in  1  flush: blocks a same-cycle issue; aborts an in-flight op.
- hi  out  WIDTH  HI register; reset 0.
- lo  out  WIDTH  LO register; reset 0.
- busy  out  1  operation in flight; reset 0.
- done  out  1  one-cycle pulse after HI/LO commit; reset 0.

## Operation
States: IDLE, RUN, FIN.

**IDLE**
- Accept when start=1, cancel=0 and busy=0.
- MTHI/MTLO write hi/lo at the accept edge and stay in IDLE; no busy, no done.
- Ops 0-3 and 6-7 latch the operands and go to RUN with iteration counter cnt=WIDTH-1.
- Signed ops latch absolute values plus result sign flags.

**RUN**
- One radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
- cnt decrements each cycle; at cnt=0, go to FIN.

**FIN**
- Apply sign fix-up.
- MADD: {hi,lo} += product. MSUB: {hi,lo} -= product. Both are 2·WIDTH-bit wraparound.
- Commit hi/lo and go to IDLE.

**Arithmetic rules**
- MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
- Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): lo = all ones, hi = rs.
- Signed MIN / -1: lo = MIN, hi = 0.

**Cancel**
- In RUN or FIN: go to IDLE at the next edge. hi/lo keep their pre-issue values; no done.
- In the same cycle as start: the issue is ignored entirely, including MTHI/MTLO.

**Other boundary conditions**
- start while busy=1 is ignored. Upstream must stall on busy; the bench asserts this never happens.
- reset mid-operation: state IDLE, hi=lo=0, busy=done=0 at the next edge.

## Timing
- Let E0 be the accept edge.
- busy is high for exactly WIDTH+1 cycles after E0: WIDTH RUN cycles plus 1 FIN cycle.
- hi/lo update at the edge ending FIN (E0+WIDTH+1).
- done is high during the following cycle; busy is 0 in that same cycle.
- A new start is accepted in the done cycle, giving back-to-back issue period WIDTH+2.
- MTHI/MTLO are visible on hi/lo the cycle after E0.
- The same latency applies to every op class. There is no data-dependent early termination.
- cancel takes effect at the edge where it is sampled: busy=0 the following cycle.

## Structure
- Package mdu_pkg holds:
  - op encoding enum (MDU_MULT … MDU_MSUB);
  - state enum (IDLE/RUN/FIN);
  - a helper function for signed-operand absolute value and sign flag.
- A natural sub-module is mdu_iter_step: the combinational single radix-2 step (add-or-pass / trial-subtract), parametrised by WIDTH.
- The FSM, counter (width $clog2(WIDTH)), operand/partial registers and HI/LO live in the top.

## Test plan
All scenarios use WIDTH=32.
- MULT rs=0xFFFFFFFE, rt=3 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
- DIVU 100/7 -> lo=14, hi=2.
- DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234, MTLO 0, then MADD 2×3 -> hi=0x1234, lo=6.
- Then MSUB 2×4 -> hi=0x1233, lo=0xFFFFFFFE.
- MULTU with cancel at RUN cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done.
- start+cancel in the same cycle with MTLO 7 -> lo unchanged.
- reset at RUN cycle 5 -> hi=lo=0, busy=0.
- Back-to-back MULT issued in the done cycle -> accepted; second done at 34 cycles after it.
